dvp_test_source: RTL



---
 rtl/dvp_test_source.sv | 309 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/dvp_test_source.sv
`default_nettype none
// ============================================================================
// Module      : dvp_test_source
// Description : OV7670-style DVP frame source. Generates pclk, vsync, href
//               and an 8-bit YUV422 byte stream of test frames from the
//               fabric clock. It stands in for the camera on the capture
//               path so the capture/memory/VGA chain and the detection
//               overlay can be exercised without a sensor.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   1   fabric clock
//   reset_n      in   1   asynchronous active-low reset
//   enable       in   1   run frames while high (a started frame always ends)
//   mode         in   2   pattern select, latched at frame start
//                         0 gradient, 1 64-px bars, 2 flat grey, 3 marker
//   marker_x     in  10   marker column, latched at frame start
//   marker_y     in   9   marker row, latched at frame start
//   pclk         out  1   pixel clock, low while idle
//   vsync        out  1   frame sync, active high
//   href         out  1   line valid, active high
//   data         out  8   byte stream (Y/Cb/Y/Cr order, chroma fixed 0x80)
//   frame_done   out  1   one-clk pulse at the end of each frame
//   frame_count  out 16   completed frames, wraps
// ----------------------------------------------------------------------------
// Build option
//   DVP_SRC_FRAMECNT_EN : when defined, the Y byte of pixel (0,0) carries
//                         frame_count[7:0] (value before this frame's
//                         increment) so the capture side can verify frame
//                         ordering. When undefined, pixel (0,0) follows the
//                         selected pattern.
// ============================================================================
module dvp_test_source #(
  parameter int PCLK_DIV    = 2,    // clk cycles per pclk period, even, >= 2
  parameter int H_ACTIVE    = 640,  // active pixels per line (2 bytes each)
  parameter int H_BLANK     = 144,  // href-low ticks per line
  parameter int V_ACTIVE    = 480,  // active lines per frame
  parameter int VSYNC_LINES = 3,    // lines with vsync high
  parameter int V_BACK      = 17,   // lines between vsync and first active line
  parameter int V_FRONT     = 10    // lines after the last active line
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [1:0]  mode,
  input  logic [9:0]  marker_x,
  input  logic [8:0]  marker_y,
  output logic        pclk,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  data,
  output logic        frame_done,
  output logic [15:0] frame_count
);

  // --------------------------------------------------------------------------
  // Derived sizes
  // --------------------------------------------------------------------------
  localparam int C_LINE_TICKS = 2 * H_ACTIVE + H_BLANK;
  localparam int C_HCNT_W     = (C_LINE_TICKS > 1) ? $clog2(C_LINE_TICKS) : 1;

  localparam int C_MAX_A   = (V_ACTIVE > VSYNC_LINES) ? V_ACTIVE : VSYNC_LINES;
  localparam int C_MAX_B   = (V_BACK > V_FRONT) ? V_BACK : V_FRONT;
  localparam int C_MAX_SEG = (C_MAX_A > C_MAX_B) ? C_MAX_A : C_MAX_B;
  localparam int C_LCNT_W  = (C_MAX_SEG > 1) ? $clog2(C_MAX_SEG) : 1;

  localparam int C_DIV_W   = (PCLK_DIV > 1) ? $clog2(PCLK_DIV) : 1;

  localparam logic [C_DIV_W-1:0]  C_DIV_LAST  = C_DIV_W'(PCLK_DIV - 1);
  // pclk rises half a period after the tick, mid-way through the data eye
  localparam logic [C_DIV_W-1:0]  C_DIV_RISE  = C_DIV_W'(PCLK_DIV / 2 - 1);
  localparam logic [C_HCNT_W-1:0] C_HCNT_LAST = C_HCNT_W'(C_LINE_TICKS - 1);
  // one extra bit so an H_BLANK of zero cannot overflow the compare
  localparam logic [C_HCNT_W:0]   C_HREF_END  = (C_HCNT_W + 1)'(2 * H_ACTIVE);

  localparam logic [C_LCNT_W-1:0] C_VSYNC_LAST  = C_LCNT_W'(VSYNC_LINES - 1);
  localparam logic [C_LCNT_W-1:0] C_VBACK_LAST  = C_LCNT_W'(V_BACK - 1);
  localparam logic [C_LCNT_W-1:0] C_ACTIVE_LAST = C_LCNT_W'(V_ACTIVE - 1);
  localparam logic [C_LCNT_W-1:0] C_VFRONT_LAST = C_LCNT_W'(V_FRONT - 1);

  localparam logic [7:0] C_CHROMA     = 8'h80;
  localparam logic [7:0] C_MARK_ON    = 8'hF0;
  localparam logic [7:0] C_MARK_OFF   = 8'h10;
  localparam logic [7:0] C_FLAT_GREY  = 8'h80;

  // --------------------------------------------------------------------------
  // Frame state machine encoding
  // --------------------------------------------------------------------------
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_VSYNC  = 3'd1,
    S_VBACK  = 3'd2,
    S_ACTIVE = 3'd3,
    S_VFRONT = 3'd4
  } state_t;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  state_t                state_q,       state_d;
  logic [C_DIV_W-1:0]    div_q,         div_d;
  logic                  pclk_q,        pclk_d;
  logic                  run_q,         run_d;
  logic [C_HCNT_W-1:0]   hcnt_q,        hcnt_d;
  logic [C_LCNT_W-1:0]   lcnt_q,        lcnt_d;
  logic [1:0]            mode_q,        mode_d;
  logic [9:0]            mx_q,          mx_d;
  logic [8:0]            my_q,          my_d;
  logic                  vsync_q,       vsync_d;
  logic                  href_q,        href_d;
  logic [7:0]            data_q,        data_d;
  logic                  frame_done_q,  frame_done_d;
  logic [15:0]           frame_count_q, frame_count_d;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic                w_tick;
  logic                w_line_end;
  logic                w_seg_end;
  logic [C_LCNT_W-1:0] w_seg_last;
  logic                w_href_now;
  logic [9:0]          w_x;
  logic [8:0]          w_y;
  logic [10:0]         w_x11;
  logic [10:0]         w_mx_lo;
  logic [10:0]         w_mx_hi;
  logic [10:0]         w_y11;
  logic [10:0]         w_my_lo;
  logic [10:0]         w_my_hi;
  logic                w_in_marker;
  logic [7:0]          w_luma;

  assign w_tick = (div_q == C_DIV_LAST);

  // --------------------------------------------------------------------------
  // Pixel generator: Y value for the pixel addressed by the current counters
  // --------------------------------------------------------------------------
  always_comb begin : p_pixel
    w_x     = 10'(hcnt_q >> 1);
    w_y     = 9'(lcnt_q);

    // Marker window compared at 11 bits so marker_x+7 near the right edge
    // cannot wrap around and light up column 0.
    w_x11   = {1'b0, w_x};
    w_mx_lo = {1'b0, mx_q};
    w_mx_hi = w_mx_lo + 11'd7;
    w_y11   = {2'b00, w_y};
    w_my_lo = {2'b00, my_q};
    w_my_hi = w_my_lo + 11'd7;
    w_in_marker = (w_x11 >= w_mx_lo) && (w_x11 <= w_mx_hi) &&
                  (w_y11 >= w_my_lo) && (w_y11 <= w_my_hi);

    w_luma = C_FLAT_GREY;
    case (mode_q)
      2'd0:    w_luma = w_x[9:2];
      2'd1:    w_luma = {8{w_x[6]}};
      2'd2:    w_luma = C_FLAT_GREY;
      2'd3:    w_luma = w_in_marker ? C_MARK_ON : C_MARK_OFF;
      default: w_luma = C_FLAT_GREY;
    endcase

`ifdef DVP_SRC_FRAMECNT_EN
    // Stamp the frame number into the first Y byte of the frame
    if ((w_x == 10'd0) && (w_y == 9'd0)) begin
      w_luma = frame_count_q[7:0];
    end
`endif
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin : p_next
    state_d       = state_q;
    div_d         = div_q;
    pclk_d        = pclk_q;
    run_d         = run_q;
    hcnt_d        = hcnt_q;
    lcnt_d        = lcnt_q;
    mode_d        = mode_q;
    mx_d          = mx_q;
    my_d          = my_q;
    vsync_d       = vsync_q;
    href_d        = href_q;
    data_d        = data_q;
    frame_done_d  = 1'b0;
    frame_count_d = frame_count_q;

    case (state_q)
      S_VSYNC:  w_seg_last = C_VSYNC_LAST;
      S_VBACK:  w_seg_last = C_VBACK_LAST;
      S_ACTIVE: w_seg_last = C_ACTIVE_LAST;
      S_VFRONT: w_seg_last = C_VFRONT_LAST;
      default:  w_seg_last = '0;
    endcase

    w_line_end = (hcnt_q == C_HCNT_LAST);
    w_seg_end  = w_line_end && (lcnt_q == w_seg_last);
    w_href_now = (state_q == S_ACTIVE) && ({1'b0, hcnt_q} < C_HREF_END);

    if (w_tick) begin
      div_d  = '0;
      pclk_d = 1'b0;
      // pclk only runs for ticks whose outputs belong to a frame, so the
      // sink sees no edges while the source is idle.
      run_d  = (state_q != S_IDLE);

      // Outputs are registered from the counters as they stand at this tick,
      // so they lag the state machine by exactly one tick.
      vsync_d = (state_q == S_VSYNC);
      href_d  = w_href_now;
      if (w_href_now) begin
        data_d = hcnt_q[0] ? C_CHROMA : w_luma;
      end else begin
        data_d = 8'h00;
      end

      if (state_q == S_IDLE) begin
        hcnt_d = '0;
        lcnt_d = '0;
        if (enable) begin
          state_d = S_VSYNC;
          mode_d  = mode;
          mx_d    = marker_x;
          my_d    = marker_y;
        end
      end else begin
        hcnt_d = w_line_end ? '0 : hcnt_q + 1'b1;
        if (w_line_end) begin
          lcnt_d = w_seg_end ? '0 : lcnt_q + 1'b1;
        end
        if (w_seg_end) begin
          case (state_q)
            S_VSYNC:  state_d = S_VBACK;
            S_VBACK:  state_d = S_ACTIVE;
            S_ACTIVE: state_d = S_VFRONT;
            S_VFRONT: begin
              frame_done_d  = 1'b1;
              frame_count_d = frame_count_q + 16'd1;
              // enable is only sampled here, so dropping it mid-frame lets
              // the current frame finish intact.
              if (enable) begin
                state_d = S_VSYNC;
                mode_d  = mode;
                mx_d    = marker_x;
                my_d    = marker_y;
              end else begin
                state_d = S_IDLE;
              end
            end
            default:  state_d = S_IDLE;
          endcase
        end
      end
    end else begin
      div_d = div_q + 1'b1;
      if (run_q && (div_q == C_DIV_RISE)) begin
        pclk_d = 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      div_q         <= '0;
      pclk_q        <= 1'b0;
      run_q         <= 1'b0;
      hcnt_q        <= '0;
      lcnt_q        <= '0;
      mode_q        <= 2'd0;
      mx_q          <= 10'd0;
      my_q          <= 9'd0;
      vsync_q       <= 1'b0;
      href_q        <= 1'b0;
      data_q        <= 8'h00;
      frame_done_q  <= 1'b0;
      frame_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      div_q         <= div_d;
      pclk_q        <= pclk_d;
      run_q         <= run_d;
      hcnt_q        <= hcnt_d;
      lcnt_q        <= lcnt_d;
      mode_q        <= mode_d;
      mx_q          <= mx_d;
      my_q          <= my_d;
      vsync_q       <= vsync_d;
      href_q        <= href_d;
      data_q        <= data_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign pclk        = pclk_q;
  assign vsync       = vsync_q;
  assign href        = href_q;
  assign data        = data_q;
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;

endmodule
`default_nettype wire
